// File: rtl/clk_enable_gen_if.sv
// Control/status bundle for clk_enable_gen: increment load path, enables, ready.
// The pause signal exists only when CLKEN_PAUSE_EN is defined.
interface clk_enable_gen_if #(
  parameter int NCH   = 3,
  parameter int ACC_W = 24
);
  logic [NCH*ACC_W-1:0] inc;
  logic                 load;
  logic [NCH-1:0]       ce;
  logic                 ready;
`ifdef CLKEN_PAUSE_EN
  logic                 pause;
`endif

  modport master (
`ifdef CLKEN_PAUSE_EN
    output pause,
`endif
    output inc, load,
    input  ce, ready
  );

  modport slave (
`ifdef CLKEN_PAUSE_EN
    input  pause,
`endif
    input  inc, load,
    output ce, ready
  );
endinterface

// File: rtl/clk_enable_gen.sv
// Multi-channel fractional clock-enable generator gated on a debounced PLL lock.
// Optional feature macro: CLKEN_PAUSE_EN (adds bus.pause to freeze all accumulators).
module clk_enable_gen #(
  parameter int                   NCH       = 3,
  parameter int                   ACC_W     = 24,
  parameter int                   LOCK_WAIT = 1024,
  parameter logic [NCH*ACC_W-1:0] INC_INIT  = '0
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            pll_lock,
  clk_enable_gen_if.slave bus
);

  localparam int               CNT_W    = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_WAIT - 1);

  typedef enum logic [1:0] {WAIT_LOCK, HOLD, RUN} state_t;

  state_t                      state, state_n;
  logic [CNT_W-1:0]            cnt, cnt_n;
  logic                        lock_meta, lock_s;
  logic                        ready_q;
  logic                        run, stall;
  logic [NCH-1:0][ACC_W-1:0]   inc_reg;
  logic [NCH-1:0][ACC_W-1:0]   acc;
  logic [NCH-1:0]              ce_q;

  // pll_lock is asynchronous to clk
  always_ff @(posedge clk) begin
    if (!resetn) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= WAIT_LOCK;
      cnt     <= '0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      ready_q <= (state_n == RUN);
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      WAIT_LOCK: begin
        cnt_n = '0;
        if (lock_s) state_n = HOLD;
      end
      HOLD: begin
        if (!lock_s) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = RUN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RUN: begin
        cnt_n = '0;
        if (!lock_s) state_n = WAIT_LOCK;
      end
      default: begin
        state_n = WAIT_LOCK;
        cnt_n   = '0;
      end
    endcase
  end

  // Adds only while staying in RUN, so ce/acc clear on the edge that leaves RUN.
  assign run = (state == RUN) && (state_n == RUN);

`ifdef CLKEN_PAUSE_EN
  assign stall = bus.pause;
`else
  assign stall = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn)       inc_reg <= INC_INIT;
    else if (bus.load) inc_reg <= bus.inc;
  end

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    logic [ACC_W:0] sum;
    assign sum = {1'b0, acc[k]} + {1'b0, inc_reg[k]};

    always_ff @(posedge clk) begin
      if (!resetn || !run) begin
        acc[k]  <= '0;
        ce_q[k] <= 1'b0;
      end else if (stall) begin
        ce_q[k] <= 1'b0;
      end else begin
        acc[k]  <= sum[ACC_W-1:0];
        ce_q[k] <= sum[ACC_W];
      end
    end
  end

  assign bus.ce    = ce_q;
  assign bus.ready = ready_q;

endmodule

// File: tb/tb_clk_enable_gen.sv
// Scoreboard bench for clk_enable_gen (NCH=3, ACC_W=8, LOCK_WAIT=16).
// Stimulus pushes expected output events; a negedge monitor pops and compares.
module tb_clk_enable_gen;
  localparam int NCH = 3, ACC_W = 8, LOCK_WAIT = 16;

  logic clk, resetn, pll_lock;
  clk_enable_gen_if #(.NCH(NCH), .ACC_W(ACC_W)) bus ();

  clk_enable_gen #(.NCH(NCH), .ACC_W(ACC_W), .LOCK_WAIT(LOCK_WAIT)) dut (
    .clk(clk), .resetn(resetn), .pll_lock(pll_lock), .bus(bus)
  );

  typedef struct {int cyc; logic [2:0] ce; logic rdy;} ev_t;
  ev_t q[$];

  int checks = 0, errors = 0, cyc = 0, cnt0 = 0;
  logic mon_en = 1'b0, prev_rdy = 1'b0;
  int b, r, e, f, g, h, s, b5, r5, m, r6, c_a;
`ifdef CLKEN_PAUSE_EN
  int p;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // an event is any cycle with a ce pulse or a ready edge
  always @(negedge clk) begin
    ev_t x;
    if (mon_en) begin
      if (bus.ce[0]) cnt0++;
      if (bus.ce != 3'b0 || bus.ready != prev_rdy) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event cyc=%0d ce=%b ready=%b", cyc, bus.ce, bus.ready);
        end else begin
          x = q.pop_front();
          if (x.cyc != cyc || x.ce != bus.ce || x.rdy != bus.ready) begin
            errors++;
            $display("FAIL sb_event got cyc=%0d ce=%b ready=%b expected cyc=%0d ce=%b ready=%b",
                     cyc, bus.ce, bus.ready, x.cyc, x.ce, x.rdy);
          end
        end
      end
      prev_rdy = bus.ready;
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic push(input int c, input logic [2:0] v, input logic rdy);
    ev_t x;
    x.cyc = c; x.ce = v; x.rdy = rdy;
    q.push_back(x);
  endtask

  // periodic pulses: channel k fires at bk+pk, bk+2pk, ... (pk=0: never)
  task automatic push_range(input int from, input int to, input int b0, input int p0,
                            input int b1, input int p1, input int b2, input int p2);
    logic [2:0] v;
    for (int t = from; t <= to; t++) begin
      v[0] = (p0 > 0) && (t > b0) && ((t - b0) % p0 == 0);
      v[1] = (p1 > 0) && (t > b1) && ((t - b1) % p1 == 0);
      v[2] = (p2 > 0) && (t > b2) && ((t - b2) % p2 == 0);
      if (v != 3'b0) push(t, v, 1'b1);
    end
  endtask

  initial begin
    logic [2:0] v;
    resetn = 1'b0; pll_lock = 1'b1; bus.inc = '0; bus.load = 1'b0;
`ifdef CLKEN_PAUSE_EN
    bus.pause = 1'b0;
`endif
    tick(3);
    check("rst_ready", int'(bus.ready), 0);
    check("rst_ce", int'(bus.ce), 0);
    mon_en = 1'b1;

    // 1: lock present from reset; sync 2 + WAIT_LOCK 1 + HOLD 16 edges
    b = cyc; resetn = 1'b1; bus.inc = {8'd0, 8'd128, 8'd64}; bus.load = 1'b1;
    r = b + 19;
    e = r + 32;
    push(r, 3'b000, 1'b1);
    push_range(r + 1, e + 2, r, 4, r, 2, r, 0);
    push(e + 3, 3'b000, 1'b0);
    tick(1); bus.load = 1'b0;
    wait_until(r - 1); check("t1_ready_pre", int'(bus.ready), 0);
    wait_until(r);     check("t1_ready_rise", int'(bus.ready), 1);

    // 3: drop lock mid-RUN; two adds still happen through the synchroniser
    wait_until(e); pll_lock = 1'b0;
    wait_until(e + 3); check("t3_ready_drop", int'(bus.ready), 0);

    // 2: glitchy relock, RUN only 19 edges after the final rise
    f = e + 6; wait_until(f); pll_lock = 1'b1;
    tick(10); pll_lock = 1'b0;
    tick(3);  pll_lock = 1'b1;
    check("t2_glitch_no_run", int'(bus.ready), 0);
    g = f + 32;
    h = g + 16;
    s = g + 300;
    push(g, 3'b000, 1'b1);
    push_range(g + 1, h, g, 4, g, 2, g, 0);
    // 4: load at h; edge h+1 still adds 64 (acc 0->64), then 32 -> carry at g+23
    push_range(h + 1, s, g + 15, 8, g, 2, g, 0);
    push(s + 1, 3'b000, 1'b0);
    wait_until(g - 1); check("t2_ready_pre", int'(bus.ready), 0);
    wait_until(g);     check("t2_ready_rise", int'(bus.ready), 1);
    wait_until(h); bus.inc = {8'd0, 8'd128, 8'd32}; bus.load = 1'b1;
    tick(1); bus.load = 1'b0;
    wait_until(g + 24); c_a = cnt0;
    wait_until(g + 280); check("t4_cnt256", cnt0 - c_a, 32);
    wait_until(s); resetn = 1'b0;
    tick(2);
    check("t4_rst_ready", int'(bus.ready), 0);
    check("t4_rst_ce", int'(bus.ce), 0);

    // 5: ch0=255 (low once per 256), ch1/ch2 identical 128 -> phase-aligned
    b5 = cyc; resetn = 1'b1; bus.inc = {8'd128, 8'd128, 8'd255}; bus.load = 1'b1;
    r5 = b5 + 19;
    m  = r5 + 300;
    push(r5, 3'b000, 1'b1);
    for (int t = r5 + 1; t <= m; t++) begin
      v[0] = (t >= r5 + 2) && ((t - r5 - 1) % 256 != 0);
      v[1] = ((t - r5) % 2 == 0);
      v[2] = v[1];
      if (v != 3'b0) push(t, v, 1'b1);
    end
    push(m + 1, 3'b000, 1'b0);
    tick(1); bus.load = 1'b0;
    wait_until(r5 + 2); c_a = cnt0;
    wait_until(r5 + 258); check("t5_cnt256", cnt0 - c_a, 255);
    wait_until(m); resetn = 1'b0;
    tick(1);
    check("t5_rst_ready_next", int'(bus.ready), 0);
    check("t5_rst_ce_next", int'(bus.ce), 0);
    tick(1); resetn = 1'b1;
    // no load after reset: INC_INIT=0 means RUN without any ce
    r6 = cyc + 19;
    push(r6, 3'b000, 1'b1);
    wait_until(r6); check("t5_ready_again", int'(bus.ready), 1);
    wait_until(r6 + 40);

`ifdef CLKEN_PAUSE_EN
    // 6: pause covers edges p+14..p+18; adds resume at p+19, carry at p+22
    p = cyc; bus.inc = {8'd0, 8'd0, 8'd64}; bus.load = 1'b1;
    push(p + 5, 3'b001, 1'b1);
    push(p + 9, 3'b001, 1'b1);
    push(p + 13, 3'b001, 1'b1);
    push(p + 22, 3'b001, 1'b1);
    push(p + 26, 3'b001, 1'b1);
    push(p + 30, 3'b001, 1'b1);
    tick(1); bus.load = 1'b0;
    wait_until(p + 13); bus.pause = 1'b1;
    wait_until(p + 18); bus.pause = 1'b0;
    check("t6_ready_in_pause", int'(bus.ready), 1);
    wait_until(p + 32);
`endif

    tick(3);
    check("sb_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
